// File: rtl/mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the multi-cycle sequencers built around the alu.
//   state_t   : sequencer FSM state encoding (IDLE, RUN, DONE), 2 bits
//   ALU_*     : alu operation select codes driven on i_alu_ctrl
// ---------------------------------------------------------------------------
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage : mul_seq_pkg

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Shared combinational N-bit ALU.
//   i_a, i_b     : operands
//   i_alu_ctrl   : ALU_ADD / ALU_SUB / ALU_AND / ALU_OR
//   o_result     : N-bit result
//   o_carry_out  : carry out of the adder (ADD), no-borrow flag (SUB),
//                  0 for logic operations
// ---------------------------------------------------------------------------
module alu
    import mul_seq_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_alu_ctrl,
    output logic [N-1:0] o_result,
    output logic         o_carry_out
);

    logic [N:0]   add_w;
    logic [N:0]   sub_w;
    logic [N-1:0] and_w;
    logic [N-1:0] or_w;

    assign add_w = {1'b0, i_a} + {1'b0, i_b};
    // Two's-complement subtract: carry out high means no borrow occurred.
    assign sub_w = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_logic
            assign and_w[gi] = i_a[gi] & i_b[gi];
            assign or_w[gi]  = i_a[gi] | i_b[gi];
        end
    endgenerate

    always_comb begin
        o_result    = add_w[N-1:0];
        o_carry_out = add_w[N];
        case (i_alu_ctrl)
            ALU_ADD: begin
                o_result    = add_w[N-1:0];
                o_carry_out = add_w[N];
            end
            ALU_SUB: begin
                o_result    = sub_w[N-1:0];
                o_carry_out = sub_w[N];
            end
            ALU_AND: begin
                o_result    = and_w;
                o_carry_out = 1'b0;
            end
            default: begin
                o_result    = or_w;
                o_carry_out = 1'b0;
            end
        endcase
    end

endmodule : alu

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Iterative unsigned N x N -> 2N shift-add multiplier using one shared alu
// in add mode. One partial product is accumulated per RUN cycle, exactly N
// cycles per product.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_valid/o_ready     : operand handshake (o_ready high only in IDLE)
//   i_a, i_b            : multiplicand / multiplier, unsigned N bits
//   o_valid/i_ready     : result handshake (o_valid high only in DONE)
//   o_product           : {hi, lo} product register, 2N bits
// ---------------------------------------------------------------------------
module alu_mul_seq
    import mul_seq_pkg::*;
#(
    parameter int N = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [2*N-1:0] o_product
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  a_q, a_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0]  alu_b;
    logic [N-1:0]  sum;
    logic          carry_out;

    // Add the multiplicand into the upper half only when the current
    // multiplier bit (lo[0]) is set.
    assign alu_b = lo_q[0] ? a_q : '0;

    alu #(.N(N)) u_alu (
        .i_a         (hi_q),
        .i_b         (alu_b),
        .i_alu_ctrl  (ALU_ADD),
        .o_result    (sum),
        .o_carry_out (carry_out)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    lo_d    = i_b;
                    hi_d    = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift the (N+1)-bit partial sum right by one across {hi, lo};
                // consumed multiplier bits fall out of lo's LSB.
                hi_d    = {carry_out, sum[N-1:1]};
                lo_d    = {sum[0], lo_q[N-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            count_q <= count_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_product = {hi_q, lo_q};

endmodule : alu_mul_seq
